// File: rtl/wave_buffer_ctrl_if.sv
// Profile-sample write channel between the waveform writer and wave_buffer_ctrl.
// The writer drives the master side; the controller answers with wr_ready.
interface wave_buffer_ctrl_if;
  logic       wr_valid;
  logic [9:0] wr_index;
  logic [9:0] wr_data;
  logic       wr_last;
  logic       wr_ready;

  modport master (
    output wr_valid,
    output wr_index,
    output wr_data,
    output wr_last,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_index,
    input  wr_data,
    input  wr_last,
    output wr_ready
  );
endinterface

// File: rtl/wave_buffer_ctrl.sv
// Double-buffered waveform profile store: one bank feeds the display, the other is refilled,
// and roles swap on vsync once a full profile has landed. WAVE_CLAMP_EN saturates stored samples.
module wave_buffer_ctrl #(
  parameter int unsigned DEFAULT_PROF = 382,
  parameter int unsigned PROF_MIN     = 0,
  parameter int unsigned PROF_MAX     = 767
) (
  input  logic                 vclock,
  input  logic                 reset,
  input  logic                 i_vsync,
  input  logic [10:0]          i_hcount,
  input  logic [10:0]          i_p_offset,
  wave_buffer_ctrl_if.slave    io_wr,
  output logic [9:0]           o_wave_prof,
  output logic                 o_swap,
  output logic                 o_overrun
);

  localparam logic [9:0] LP_DEFAULT = 10'(DEFAULT_PROF);

  typedef enum logic [1:0] {StFill, StDone, StSwap} state_e;

  state_e      r_state;
  logic        r_wr_ready;
  logic        r_disp;      // 0: bank0 displayed, bank1 filled
  logic        r_swapped;
  logic        r_vsync;
  logic        r_swap;
  logic        r_overrun;
  logic [10:0] r_offset;
  logic [9:0]  r_wave_prof;
  logic [9:0]  r_bank0 [1024];
  logic [9:0]  r_bank1 [1024];

  logic        w_frame_edge;
  logic        w_accept;
  logic [9:0]  w_addr;
  logic [9:0]  w_store;

  function automatic logic [9:0] f_clamp(input logic [9:0] d);
    if (d >= 10'(PROF_MAX)) return 10'(PROF_MAX);
    if (d <= 10'(PROF_MIN)) return 10'(PROF_MIN);
    return d;
  endfunction

  assign w_frame_edge = r_vsync & ~i_vsync;
  assign w_accept     = io_wr.wr_valid & r_wr_ready;
  assign w_addr       = 10'(i_hcount + r_offset);

`ifdef WAVE_CLAMP_EN
  assign w_store = f_clamp(io_wr.wr_data);
`else
  assign w_store = io_wr.wr_data;
`endif

  always_ff @(posedge vclock) begin
    if (reset) begin
      r_state    <= StFill;
      r_wr_ready <= 1'b0;
      r_disp     <= 1'b0;
      r_swapped  <= 1'b0;
      r_offset   <= '0;
      r_vsync    <= 1'b0;
      r_swap     <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_vsync   <= i_vsync;
      r_swap    <= 1'b0;
      r_overrun <= 1'b0;
      case (r_state)
        StFill: begin
          // A frame edge while filling is an overrun even if the last sample lands now.
          r_overrun <= w_frame_edge;
          if (w_accept && io_wr.wr_last) begin
            r_state    <= StDone;
            r_wr_ready <= 1'b0;
          end else begin
            r_wr_ready <= 1'b1;
          end
        end
        StDone: begin
          if (w_frame_edge) begin
            r_state   <= StSwap;
            r_disp    <= ~r_disp;
            r_offset  <= i_p_offset;
            r_swapped <= 1'b1;
            r_swap    <= 1'b1;
          end
        end
        StSwap: begin
          r_state    <= StFill;
          r_wr_ready <= 1'b1;
        end
        default: begin
          r_state    <= StFill;
          r_wr_ready <= 1'b0;
        end
      endcase
    end
  end

  // Fill bank is always the one not displayed; wr_ready is low during SWAP.
  always_ff @(posedge vclock) begin
    if (w_accept) begin
      if (r_disp) r_bank0[io_wr.wr_index] <= w_store;
      else        r_bank1[io_wr.wr_index] <= w_store;
    end
  end

  always_ff @(posedge vclock) begin
    if (reset || !r_swapped) begin
      r_wave_prof <= LP_DEFAULT;
    end else begin
      r_wave_prof <= r_disp ? r_bank1[w_addr] : r_bank0[w_addr];
    end
  end

  assign io_wr.wr_ready = r_wr_ready;
  assign o_wave_prof    = r_wave_prof;
  assign o_swap         = r_swap;
  assign o_overrun      = r_overrun;

endmodule

// File: tb/tb_wave_buffer_ctrl.sv
// Self-checking bench for wave_buffer_ctrl: random writer/vsync/hcount traffic compared each
// cycle with a bank/role model, plus directed wrap, clamp, overrun and reset-in-DONE cases.
module tb_wave_buffer_ctrl;

  logic        vclock = 1'b0;
  logic        reset = 1'b1;
  logic        vsync = 1'b1;
  logic [10:0] hcount = '0;
  logic [10:0] p_offset = '0;
  logic [9:0]  wave_prof;
  logic        swap;
  logic        overrun;

  int vectors = 0;
  int fails = 0;

  wave_buffer_ctrl_if u_if ();

  wave_buffer_ctrl u_dut (
    .vclock      (vclock),
    .reset       (reset),
    .i_vsync     (vsync),
    .i_hcount    (hcount),
    .i_p_offset  (p_offset),
    .io_wr       (u_if),
    .o_wave_prof (wave_prof),
    .o_swap      (swap),
    .o_overrun   (overrun)
  );

  always #5 vclock = ~vclock;

  // Reference model state
  int m_bank [2][1024];
  bit m_disp, m_started, m_ready, m_prev_vs, m_acc;
  int m_phase;   // 0 filling, 1 profile complete, 2 swapping
  int m_off;
  int e_prof;
  bit e_swap, e_ovr;

  function automatic int stored(input int d);
`ifdef WAVE_CLAMP_EN
    return (d > 767) ? 767 : d;
`else
    return d;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit edge_now;
    if (reset) begin
      m_phase = 0; m_disp = 0; m_off = 0; m_started = 0; m_ready = 0; m_acc = 0;
      m_prev_vs = 0; e_swap = 0; e_ovr = 0; e_prof = 382;
    end else begin
      edge_now = m_prev_vs && !vsync;
      m_acc = u_if.wr_valid && m_ready;
      e_prof = m_started ? m_bank[m_disp][(int'(hcount) + m_off) % 1024] : 382;
      if (m_acc) m_bank[!m_disp][u_if.wr_index] = stored(int'(u_if.wr_data));
      e_swap = 0;
      e_ovr = 0;
      if (m_phase == 0) begin
        e_ovr = edge_now;
        if (m_acc && u_if.wr_last) m_phase = 1;
      end else if (m_phase == 1) begin
        if (edge_now) begin
          m_phase = 2; m_disp = !m_disp; m_off = int'(p_offset); m_started = 1; e_swap = 1;
        end
      end else begin
        m_phase = 0;
      end
      m_ready = (m_phase == 0);
      m_prev_vs = vsync;
    end
    @(posedge vclock);
    #1;
    chk("wave_prof", 32'(wave_prof), 32'(e_prof));
    chk("swap", 32'(swap), 32'(e_swap));
    chk("overrun", 32'(overrun), 32'(e_ovr));
    chk("wr_ready", 32'(u_if.wr_ready), 32'(m_ready));
  endtask

  // mode 0: data=index, 1: random, 2: index with 900 at column 3
  task automatic write_frame(input int mode, input bit edge_on_last);
    for (int i = 0; i < 1024; i++) begin
      bit done = 0;
      int tries = 0;
      while (!done) begin
        u_if.wr_index = 10'(i);
        u_if.wr_data  = (mode == 0) ? 10'(i) : (mode == 1) ? 10'($urandom_range(1023)) :
                        ((i == 3) ? 10'd900 : 10'(i));
        u_if.wr_last  = (i == 1023);
        u_if.wr_valid = (i == 1023) || ($urandom_range(3) != 0);
        hcount   = 11'($urandom_range(2047));
        p_offset = 11'($urandom_range(2047));
        if (i == 1023)     vsync = !edge_on_last;
        else if (i < 1000) vsync = ($urandom_range(63) != 0);
        else               vsync = 1'b1;
        step();
        done = m_acc;
        if (!done && ++tries > 50) begin
          vectors++;
          fails++;
          $error("FAIL accept_timeout: index %0d not accepted, wr_ready %0d", i, u_if.wr_ready);
          done = 1;
        end
      end
    end
    u_if.wr_valid = 1'b0;
    u_if.wr_last  = 1'b0;
    vsync = 1'b1;
  endtask

  task automatic frame_edge(input int off, input bit exp_swap);
    p_offset = 11'(off);
    vsync = 1'b0;
    step();
    chk("edge_swap", 32'(swap), 32'(exp_swap));
    chk("edge_overrun", 32'(overrun), 32'(!exp_swap));
    vsync = 1'b1;
    p_offset = 11'($urandom_range(2047));
    step();
    chk("swap_one_cycle", 32'(swap), 32'd0);
  endtask

  initial begin
    u_if.wr_valid = 1'b0;
    u_if.wr_index = '0;
    u_if.wr_data  = '0;
    u_if.wr_last  = 1'b0;

    // Reset state
    repeat (3) step();
    chk("rst_ready", 32'(u_if.wr_ready), 32'd0);
    chk("rst_prof", 32'(wave_prof), 32'd382);
    reset = 1'b0;
    step();
    chk("ready_after_rst", 32'(u_if.wr_ready), 32'd1);

    // No writes, vsync toggling: default profile, overruns, no swaps
    for (int i = 0; i < 40; i++) begin
      vsync  = ($urandom_range(1) != 0);
      hcount = 11'($urandom_range(2047));
      step();
    end
    vsync = 1'b1;
    step();
    frame_edge(0, 1'b0);
    chk("idle_prof", 32'(wave_prof), 32'd382);

    // Identity profile, offset 0
    write_frame(0, 1'b0);
    repeat (3) step();
    frame_edge(0, 1'b1);
    hcount = 11'd5;
    step();
    chk("hcount5", 32'(wave_prof), 32'd5);
    for (int i = 0; i < 20; i++) begin
      hcount = 11'($urandom_range(2047));
      step();
    end

    // Random profile, offset 1020 wrap-around
    write_frame(1, 1'b0);
    step();
    frame_edge(1020, 1'b1);
    hcount = 11'd10;
    step();
    chk("wrap_h10", 32'(wave_prof), 32'(m_bank[m_disp][6]));
    hcount = 11'd1030;
    step();
    chk("wrap_h1030", 32'(wave_prof), 32'(m_bank[m_disp][2]));

    // Last sample on the frame edge: overrun now, swap on the next edge
    write_frame(1, 1'b1);
    chk("last_on_edge_ovr", 32'(overrun), 32'd1);
    chk("last_on_edge_swap", 32'(swap), 32'd0);
    vsync = 1'b1;
    repeat (2) step();
    frame_edge(0, 1'b1);

    // Out-of-range sample at column 3
    write_frame(2, 1'b0);
    step();
    frame_edge(0, 1'b1);
    hcount = 11'd3;
    step();
`ifdef WAVE_CLAMP_EN
    chk("clamp_col3", 32'(wave_prof), 32'd767);
`else
    chk("clamp_col3", 32'(wave_prof), 32'd900);
`endif

    // Reset while DONE abandons the swap
    write_frame(1, 1'b0);
    step();
    reset = 1'b1;
    repeat (2) step();
    chk("rst_done_ready", 32'(u_if.wr_ready), 32'd0);
    reset = 1'b0;
    repeat (2) step();
    frame_edge(0, 1'b0);
    chk("rst_done_prof", 32'(wave_prof), 32'd382);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
